ct_spsram_param: RTL and testbench

CT_SPSRAM_PARAM -- requirements
Module: ct_spsram_param

---
 rtl/ct_spsram_pkg.sv | 16 +
 rtl/ct_spsram_array.sv | 47 ++++
 rtl/ct_spsram_param.sv | 180 ++++++++++++++++++
 tb/tb_ct_spsram_param.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ct_spsram_pkg.sv
// Shared definitions for the ct_spsram single-port SRAM wrapper:
// default geometry and the state type of the optional power-up clearing FSM.
package ct_spsram_pkg;

   localparam int DEF_ADDR_WIDTH = 9;
   localparam int DEF_DATA_WIDTH = 59;
   localparam int DEF_WE_WIDTH   = 59;
   localparam int DEF_OUT_REG    = 0;

   // INIT: array is being cleared word by word; READY: requests are accepted.
   typedef enum logic {
      ST_INIT  = 1'b0,
      ST_READY = 1'b1
   } init_state_t;

endpackage

// File: rtl/ct_spsram_array.sv
// Storage core for ct_spsram_param: one word per address, per-group write
// masking, registered read data (1-cycle latency). Deliberately has no reset so
// it maps onto a plain memory macro; read and write never happen together.
module ct_spsram_array
   import ct_spsram_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int WE_WIDTH   = DEF_WE_WIDTH
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic                  re,
   input  logic [WE_WIDTH-1:0]   wmask,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [DATA_WIDTH-1:0] wdata,
   output logic [DATA_WIDTH-1:0] rdata
);

   // A zero group count is rejected by the top; keep the division legal here.
   localparam int GROUP_W = (WE_WIDTH == 0) ? 1 : (DATA_WIDTH / WE_WIDTH);
   localparam int DEPTH   = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [DATA_WIDTH-1:0] rdata_r;

   // Masked write: only groups whose mask bit is set take the new data.
   always_ff @(posedge clk) begin
      if (we) begin
         for (int g = 0; g < WE_WIDTH; g++) begin
            if (wmask[g]) begin
               mem_r[addr][g*GROUP_W +: GROUP_W] <= wdata[g*GROUP_W +: GROUP_W];
            end
         end
      end
   end

   // Read register: updated only on a read, so it holds across other cycles.
   always_ff @(posedge clk) begin
      if (re) begin
         rdata_r <= mem_r[addr];
      end
   end

   assign rdata = rdata_r;

endmodule

// File: rtl/ct_spsram_param.sv
// ct_spsram_param: parameterised single-port SRAM with active-low controls,
// request gating on INIT_DONE, optional output register (OUT_REG) and an
// optional power-up clearing sequence enabled by the macro CT_SPSRAM_INIT_EN.
// Without CT_SPSRAM_INIT_EN the array starts undefined and INIT_DONE rises on
// the first clock edge after RST is released.
module ct_spsram_param
   import ct_spsram_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int WE_WIDTH   = DEF_WE_WIDTH,
   parameter int OUT_REG    = DEF_OUT_REG
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CEN,
   input  logic                  GWEN,
   input  logic [WE_WIDTH-1:0]   WEN,
   input  logic [ADDR_WIDTH-1:0] A,
   input  logic [DATA_WIDTH-1:0] D,
   output logic [DATA_WIDTH-1:0] Q,
   output logic                  INIT_DONE
);

   localparam int WE_SAFE = (WE_WIDTH == 0) ? 1 : WE_WIDTH;

   // Reject geometries the group masking cannot represent.
   if (WE_WIDTH == 0) begin : g_err_we_zero
      $error("ct_spsram_param: WE_WIDTH must be non-zero");
   end
   if ((DATA_WIDTH % WE_SAFE) != 0) begin : g_err_we_div
      $error("ct_spsram_param: DATA_WIDTH must be a multiple of WE_WIDTH");
   end
   if ((OUT_REG != 0) && (OUT_REG != 1)) begin : g_err_out_reg
      $error("ct_spsram_param: OUT_REG must be 0 or 1");
   end

   logic                  init_done_r;
   logic                  req_s;
   logic                  rd_s;
   logic                  wr_s;
   logic                  arr_we_s;
   logic [WE_WIDTH-1:0]   arr_mask_s;
   logic [ADDR_WIDTH-1:0] arr_addr_s;
   logic [DATA_WIDTH-1:0] arr_d_s;
   logic [DATA_WIDTH-1:0] arr_q_s;

   // A user request is only honoured once the array is ready and not in reset.
   assign req_s = ~CEN & init_done_r & ~RST;
   assign rd_s  = req_s & GWEN;
   assign wr_s  = req_s & ~GWEN;

`ifdef CT_SPSRAM_INIT_EN
   init_state_t           state_r;
   init_state_t           state_nxt_s;
   logic [ADDR_WIDTH-1:0] cnt_r;
   logic [ADDR_WIDTH-1:0] cnt_nxt_s;
   logic                  init_wr_s;

   // Clearing FSM: zero one word per cycle, leave INIT after the last address
   // by comparison rather than counter wrap.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      init_wr_s   = 1'b0;
      case (state_r)
         ST_INIT: begin
            init_wr_s = ~RST;
            if (cnt_r == {ADDR_WIDTH{1'b1}}) begin
               state_nxt_s = ST_READY;
            end else begin
               cnt_nxt_s = cnt_r + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            end
         end
         ST_READY: begin
            state_nxt_s = ST_READY;
         end
         default: begin
            state_nxt_s = ST_INIT;
         end
      endcase
   end

   // FSM state, clear counter and ready flag; RST restarts the clearing pass.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r     <= ST_INIT;
         cnt_r       <= {ADDR_WIDTH{1'b0}};
         init_done_r <= 1'b0;
      end else begin
         state_r     <= state_nxt_s;
         cnt_r       <= cnt_nxt_s;
         init_done_r <= (state_nxt_s == ST_READY);
      end
   end

   // Array port steering: the clearing pass owns the port while in INIT.
   always_comb begin
      if (init_wr_s) begin
         arr_we_s   = 1'b1;
         arr_mask_s = {WE_WIDTH{1'b1}};
         arr_addr_s = cnt_r;
         arr_d_s    = {DATA_WIDTH{1'b0}};
      end else begin
         arr_we_s   = wr_s;
         arr_mask_s = ~WEN;
         arr_addr_s = A;
         arr_d_s    = D;
      end
   end
`else
   // Ready flag: set on the first edge after RST is released.
   always_ff @(posedge CLK) begin
      if (RST) begin
         init_done_r <= 1'b0;
      end else begin
         init_done_r <= 1'b1;
      end
   end

   // Array port steering: user requests only.
   always_comb begin
      arr_we_s   = wr_s;
      arr_mask_s = ~WEN;
      arr_addr_s = A;
      arr_d_s    = D;
   end
`endif

   ct_spsram_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .WE_WIDTH   (WE_WIDTH)
   ) u_array (
      .clk   (CLK),
      .we    (arr_we_s),
      .re    (rd_s),
      .wmask (arr_mask_s),
      .addr  (arr_addr_s),
      .wdata (arr_d_s),
      .rdata (arr_q_s)
   );

   if (OUT_REG == 1) begin : g_out_reg
      logic                  rd_d1_r;
      logic [DATA_WIDTH-1:0] out_r;

      // Output stage: capture array data one cycle after a read, else hold.
      always_ff @(posedge CLK) begin
         if (RST) begin
            rd_d1_r <= 1'b0;
            out_r   <= {DATA_WIDTH{1'b0}};
         end else begin
            rd_d1_r <= rd_s;
            if (rd_d1_r) begin
               out_r <= arr_q_s;
            end
         end
      end

      assign Q = out_r;
   end else begin : g_no_out_reg
      logic q_zero_r;

      // The array read register has no reset, so mask it to zero from reset
      // until the first accepted read refreshes it.
      always_ff @(posedge CLK) begin
         if (RST) begin
            q_zero_r <= 1'b1;
         end else if (rd_s) begin
            q_zero_r <= 1'b0;
         end
      end

      assign Q = q_zero_r ? {DATA_WIDTH{1'b0}} : arr_q_s;
   end

   assign INIT_DONE = init_done_r;

endmodule

// File: tb/tb_ct_spsram_param.sv
// Self-checking bench for ct_spsram_param: a default-geometry instance (dut0)
// and a small OUT_REG=1 instance (dut1). Expected read data is pushed to a
// scoreboard when the read is driven and popped when Q is due.
module tb_ct_spsram_param;

   localparam int AW0 = 9;
   localparam int DW0 = 59;
   localparam int WW0 = 59;
   localparam int AW1 = 4;
   localparam int DW1 = 32;
   localparam int WW1 = 4;

`ifdef CT_SPSRAM_INIT_EN
   localparam int EXP_RDY0 = 512;
   localparam int EXP_RDY1 = 16;
`else
   localparam int EXP_RDY0 = 1;
   localparam int EXP_RDY1 = 1;
`endif

   logic           clk = 1'b0;
   logic           rst0, cen0, gwen0, done0;
   logic [WW0-1:0] wen0;
   logic [AW0-1:0] a0;
   logic [DW0-1:0] d0, q0;
   logic           rst1, cen1, gwen1, done1;
   logic [WW1-1:0] wen1;
   logic [AW1-1:0] a1;
   logic [DW1-1:0] d1, q1;

   typedef struct {
      logic [DW1-1:0] data;
      int             due;
   } sb1_t;

   logic [DW0-1:0] sb0[$];
   sb1_t           sb1[$];
   logic [DW0-1:0] last0;
   logic [DW1-1:0] last1;
   int             cyc = 0;
   int             vecs = 0;
   int             errs = 0;

   always #5 clk = ~clk;

   ct_spsram_param dut0 (
      .CLK(clk), .RST(rst0), .CEN(cen0), .GWEN(gwen0), .WEN(wen0),
      .A(a0), .D(d0), .Q(q0), .INIT_DONE(done0)
   );

   ct_spsram_param #(
      .ADDR_WIDTH(AW1), .DATA_WIDTH(DW1), .WE_WIDTH(WW1), .OUT_REG(1)
   ) dut1 (
      .CLK(clk), .RST(rst1), .CEN(cen1), .GWEN(gwen1), .WEN(wen1),
      .A(a1), .D(d1), .Q(q1), .INIT_DONE(done1)
   );

   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic drv0(input logic cen, input logic gwen, input logic [WW0-1:0] wen,
                       input logic [AW0-1:0] a, input logic [DW0-1:0] d);
      cen0 = cen; gwen0 = gwen; wen0 = wen; a0 = a; d0 = d;
   endtask

   task automatic drv1(input logic cen, input logic gwen, input logic [AW1-1:0] a,
                       input logic [DW1-1:0] d);
      cen1 = cen; gwen1 = gwen; wen1 = {WW1{1'b0}}; a1 = a; d1 = d;
   endtask

   task automatic test_reset();
      int n0, n1;
      logic [DW0-1:0] exp;
      rst0 = 1'b1; rst1 = 1'b1;
      drv0(1'b1, 1'b1, {WW0{1'b1}}, '0, '0);
      drv1(1'b1, 1'b1, '0, '0);
      tick(); tick();
      vecs++; if (q0 !== {DW0{1'b0}}) begin errs++; $display("FAIL reset_q0: got %h want 0", q0); end
      vecs++; if (done0 !== 1'b0) begin errs++; $display("FAIL reset_done0: got %b want 0", done0); end
      vecs++; if (q1 !== {DW1{1'b0}}) begin errs++; $display("FAIL reset_q1: got %h want 0", q1); end
      vecs++; if (done1 !== 1'b0) begin errs++; $display("FAIL reset_done1: got %b want 0", done1); end
      rst0 = 1'b0; rst1 = 1'b0;
      n0 = 0; n1 = 0;
      for (int k = 1; k <= 1000; k++) begin
         tick();
         if (n0 == 0 && done0 === 1'b1) n0 = k;
         if (n1 == 0 && done1 === 1'b1) n1 = k;
         if (n0 != 0 && n1 != 0) break;
      end
      vecs++; if (n0 != EXP_RDY0) begin errs++; $display("FAIL ready_cycles0: got %0d want %0d", n0, EXP_RDY0); end
      vecs++; if (n1 != EXP_RDY1) begin errs++; $display("FAIL ready_cycles1: got %0d want %0d", n1, EXP_RDY1); end
      vecs++; if (q0 !== {DW0{1'b0}}) begin errs++; $display("FAIL post_reset_q0: got %h want 0", q0); end
      last0 = {DW0{1'b0}};
      last1 = {DW1{1'b0}};
`ifdef CT_SPSRAM_INIT_EN
      drv0(1'b0, 1'b1, {WW0{1'b1}}, 9'h1FF, '0);
      sb0.push_back({DW0{1'b0}});
      tick();
      drv0(1'b1, 1'b1, {WW0{1'b1}}, '0, '0);
      exp = sb0.pop_front();
      vecs++; if (q0 !== exp) begin errs++; $display("FAIL init_zero_1ff: got %h want %h", q0, exp); end
      last0 = exp;
`endif
   endtask

   task automatic test_write_read();
      logic [DW0-1:0] exp;
      drv0(1'b0, 1'b0, {WW0{1'b0}}, 9'h1A5, 59'h5_5555_5555_5555);
      tick();
      vecs++; if (q0 !== last0) begin errs++; $display("FAIL wr_hold_q: got %h want %h", q0, last0); end
      drv0(1'b0, 1'b1, {WW0{1'b1}}, 9'h1A5, '0);
      sb0.push_back(59'h5_5555_5555_5555);
      tick();
      drv0(1'b1, 1'b1, {WW0{1'b1}}, '0, '0);
      exp = sb0.pop_front();
      vecs++; if (q0 !== exp) begin errs++; $display("FAIL read_1a5: got %h want %h", q0, exp); end
      last0 = exp;
   endtask

   task automatic test_mask();
      logic [DW0-1:0] exp, ones, dat;
      logic [WW0-1:0] wen;
      ones = {DW0{1'b1}};
      drv0(1'b0, 1'b0, {WW0{1'b0}}, 9'd3, ones);
      tick();
      wen = {WW0{1'b1}} << 29;
      dat = {DW0{1'b0}};
      drv0(1'b0, 1'b0, wen, 9'd3, dat);
      tick();
      vecs++; if (q0 !== last0) begin errs++; $display("FAIL mask_wr_hold: got %h want %h", q0, last0); end
      exp = ones;
      for (int g = 0; g < WW0; g++) if (!wen[g]) exp[g] = dat[g];
      drv0(1'b0, 1'b1, {WW0{1'b1}}, 9'd3, '0);
      sb0.push_back(exp);
      tick();
      drv0(1'b1, 1'b1, {WW0{1'b1}}, '0, '0);
      exp = sb0.pop_front();
      vecs++; if (q0 !== exp) begin errs++; $display("FAIL mask_read_3: got %h want %h", q0, exp); end
      last0 = exp;
   endtask

   task automatic test_back_to_back();
      logic [DW0-1:0] exp, mask3;
      mask3 = last0;
      drv0(1'b0, 1'b0, {WW0{1'b0}}, 9'd7, 59'h123_4567_89AB_CDEF);
      tick();
      vecs++; if (q0 !== last0) begin errs++; $display("FAIL b2b_wr_hold: got %h want %h", q0, last0); end
      drv0(1'b0, 1'b1, {WW0{1'b1}}, 9'd7, '0);
      sb0.push_back(59'h123_4567_89AB_CDEF);
      tick();
      exp = sb0.pop_front();
      vecs++; if (q0 !== exp) begin errs++; $display("FAIL b2b_read_7: got %h want %h", q0, exp); end
      drv0(1'b0, 1'b1, {WW0{1'b1}}, 9'd3, '0);
      sb0.push_back(mask3);
      tick();
      exp = sb0.pop_front();
      vecs++; if (q0 !== exp) begin errs++; $display("FAIL b2b_read_3: got %h want %h", q0, exp); end
      drv0(1'b0, 1'b1, {WW0{1'b1}}, 9'h1A5, '0);
      sb0.push_back(59'h5_5555_5555_5555);
      tick();
      drv0(1'b1, 1'b1, {WW0{1'b1}}, '0, '0);
      exp = sb0.pop_front();
      vecs++; if (q0 !== exp) begin errs++; $display("FAIL b2b_read_1a5: got %h want %h", q0, exp); end
      last0 = exp;
   endtask

   task automatic test_hold();
      logic [DW0-1:0] exp;
      for (int k = 0; k < 3; k++) begin
         drv0(1'b1, 1'b0, {WW0{1'b0}}, 9'd7, 59'h0AA_AAAA_AAAA_AAAA);
         tick();
         vecs++; if (q0 !== last0) begin errs++; $display("FAIL idle_hold_%0d: got %h want %h", k, q0, last0); end
      end
      drv0(1'b0, 1'b1, {WW0{1'b1}}, 9'd7, '0);
      sb0.push_back(59'h123_4567_89AB_CDEF);
      tick();
      drv0(1'b1, 1'b1, {WW0{1'b1}}, '0, '0);
      exp = sb0.pop_front();
      vecs++; if (q0 !== exp) begin errs++; $display("FAIL idle_no_write: got %h want %h", q0, exp); end
      last0 = exp;
   endtask

   task automatic test_midreset();
      logic [DW0-1:0] exp;
      int n;
`ifdef CT_SPSRAM_INIT_EN
      rst0 = 1'b1; tick(); rst0 = 1'b0;
      for (int c = 1; c <= 200; c++) begin
         if (c == 100) drv0(1'b0, 1'b0, {WW0{1'b0}}, 9'd5, {DW0{1'b1}});
         else          drv0(1'b1, 1'b1, {WW0{1'b1}}, '0, '0);
         tick();
         if (c == 100) begin
            vecs++; if (done0 !== 1'b0) begin errs++; $display("FAIL mid_done_at_100: got %b want 0", done0); end
            vecs++; if (q0 !== {DW0{1'b0}}) begin errs++; $display("FAIL mid_q_at_100: got %h want 0", q0); end
         end
      end
      exp = {DW0{1'b0}};
`else
      drv0(1'b0, 1'b0, {WW0{1'b0}}, 9'd9, 59'h0F0_F0F0_F0F0_F0F0);
      tick();
      rst0 = 1'b1;
      drv0(1'b0, 1'b0, {WW0{1'b0}}, 9'd9, 59'h70F_0F0F_0F0F_0F0F);
      tick();
      exp = 59'h0F0_F0F0_F0F0_F0F0;
`endif
      rst0 = 1'b1;
      drv0(1'b1, 1'b1, {WW0{1'b1}}, '0, '0);
      tick();
      vecs++; if (q0 !== {DW0{1'b0}}) begin errs++; $display("FAIL mid_reset_q: got %h want 0", q0); end
      vecs++; if (done0 !== 1'b0) begin errs++; $display("FAIL mid_reset_done: got %b want 0", done0); end
      rst0 = 1'b0;
      n = 0;
      for (int k = 1; k <= 1000; k++) begin
         tick();
         if (done0 === 1'b1) begin n = k; break; end
      end
      vecs++; if (n != EXP_RDY0) begin errs++; $display("FAIL mid_ready_cycles: got %0d want %0d", n, EXP_RDY0); end
`ifdef CT_SPSRAM_INIT_EN
      drv0(1'b0, 1'b1, {WW0{1'b1}}, 9'd5, '0);
`else
      drv0(1'b0, 1'b1, {WW0{1'b1}}, 9'd9, '0);
`endif
      sb0.push_back(exp);
      tick();
      drv0(1'b1, 1'b1, {WW0{1'b1}}, '0, '0);
      exp = sb0.pop_front();
      vecs++; if (q0 !== exp) begin errs++; $display("FAIL mid_ignored_write: got %h want %h", q0, exp); end
   endtask

   task automatic test_out_reg();
      sb1_t e;
      drv1(1'b0, 1'b0, 4'd1, 32'h0000_00A1);
      tick();
      drv1(1'b0, 1'b0, 4'd2, 32'h0000_00B2);
      tick();
      vecs++; if (q1 !== last1) begin errs++; $display("FAIL oreg_wr_hold: got %h want %h", q1, last1); end
      for (int s = 0; s < 7; s++) begin
         if (s == 0) begin
            drv1(1'b0, 1'b1, 4'd1, '0);
            sb1.push_back('{data: 32'h0000_00A1, due: cyc + 2});
         end else if (s == 1) begin
            drv1(1'b0, 1'b1, 4'd2, '0);
            sb1.push_back('{data: 32'h0000_00B2, due: cyc + 2});
         end else begin
            drv1(1'b1, 1'b1, 4'd5, '0);
         end
         tick();
         if (sb1.size() > 0 && sb1[0].due == cyc) begin
            e = sb1.pop_front();
            last1 = e.data;
            vecs++; if (q1 !== e.data) begin errs++; $display("FAIL oreg_read_s%0d: got %h want %h", s, q1, e.data); end
         end else begin
            vecs++; if (q1 !== last1) begin errs++; $display("FAIL oreg_hold_s%0d: got %h want %h", s, q1, last1); end
         end
      end
      vecs++; if (sb1.size() != 0) begin errs++; $display("FAIL oreg_pending: got %0d want 0", sb1.size()); end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_mask();
      test_back_to_back();
      test_hold();
      test_midreset();
      test_out_reg();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
